// File: rtl/fir_out_pkg.sv
// Shared types and constant helpers for the FIR output quantizer.
package fir_out_pkg;

    localparam int unsigned SAMPLE_W = 64;

    typedef struct packed {
        logic                       valid;
        logic signed [SAMPLE_W-1:0] data;
    } pipe_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) r = r + 1;
        return r;
    endfunction

    function automatic logic signed [SAMPLE_W-1:0] sat_max(input int unsigned w);
        logic signed [SAMPLE_W-1:0] one;
        one = SAMPLE_W'(1);
        return (one <<< (w - 1)) - one;
    endfunction

    function automatic logic signed [SAMPLE_W-1:0] sat_min(input int unsigned w);
        return ~sat_max(w);
    endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO only lands when a pop frees a slot.
module fir_out_fifo
    import fir_out_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic [WIDTH-1:0]            pop_data,
    output logic                        full,
    output logic                        empty,
    output logic [clog2(DEPTH):0]       count
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;
    logic [CW-1:0]    count_nxt;

    // An empty FIFO never pops, so a same-cycle push cannot bypass to the head.
    always_comb begin
        pop_ok    = pop && !empty;
        push_ok   = push && (!full || pop_ok);
        count_nxt = count + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == CW'(DEPTH));
        end
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/fir_out_quantizer.sv
// Rounds, shifts, saturates and decimates FIR results into a small output FIFO.
// Optional FIR_OUT_QUANTIZER_SATCNT_EN adds a saturating 16-bit clamp counter.
module fir_out_quantizer
    import fir_out_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH  = 33,
    parameter int unsigned OUTPUT_WIDTH = 16,
    parameter int unsigned SHIFT        = 16,
    parameter int unsigned DECIM        = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [INPUT_WIDTH-1:0]  in_data,
    input  logic                    in_valid,
    output logic [OUTPUT_WIDTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    clear_flags,
    output logic                    sat_flag,
    output logic                    drop_flag
`ifdef FIR_OUT_QUANTIZER_SATCNT_EN
    ,
    output logic [15:0]             sat_count
`endif
);

    localparam int unsigned XW  = INPUT_WIDTH + 1;
    localparam int unsigned DCW = (DECIM > 1) ? clog2(DECIM) : 1;
    localparam int unsigned CW  = clog2(FIFO_DEPTH) + 1;

    localparam logic signed [XW-1:0]       HALF    = XW'(1) << (SHIFT - 1);
    localparam logic signed [SAMPLE_W-1:0] OMAX    = sat_max(OUTPUT_WIDTH);
    localparam logic signed [SAMPLE_W-1:0] OMIN    = sat_min(OUTPUT_WIDTH);
    localparam logic [OUTPUT_WIDTH-1:0]    OUT_MAX = OMAX[OUTPUT_WIDTH-1:0];
    localparam logic [OUTPUT_WIDTH-1:0]    OUT_MIN = OMIN[OUTPUT_WIDTH-1:0];

    pipe_t                    s1_q;
    logic                     s2_valid;
    logic [OUTPUT_WIDTH-1:0]  s2_data;
    logic signed [XW-1:0]     rnd_sum;
    logic signed [XW-1:0]     rnd_shr;
    logic                     clamp_hi;
    logic                     clamp_lo;
    logic                     sat_ev;
    logic [OUTPUT_WIDTH-1:0]  clamped;
    logic [DCW-1:0]           dec_cnt;
    logic                     push;
    logic                     pop;
    logic                     drop_ev;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [CW-1:0]            unused_fifo_count;

    // One extra bit of headroom keeps the rounding add from wrapping.
    always_comb begin
        rnd_sum  = XW'($signed(in_data)) + HALF;
        rnd_shr  = rnd_sum >>> SHIFT;
        clamp_hi = $signed(s1_q.data) > OMAX;
        clamp_lo = $signed(s1_q.data) < OMIN;
        clamped  = s1_q.data[OUTPUT_WIDTH-1:0];
        if (clamp_hi) clamped = OUT_MAX;
        if (clamp_lo) clamped = OUT_MIN;
        sat_ev   = s1_q.valid && (clamp_hi || clamp_lo);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q     <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else begin
            s1_q     <= '{valid: in_valid, data: SAMPLE_W'(rnd_shr)};
            s2_valid <= s1_q.valid;
            s2_data  <= clamped;
        end
    end

    assign push    = s2_valid && (dec_cnt == '0);
    assign pop     = out_valid && out_ready;
    assign drop_ev = push && fifo_full && !pop;

    // Set events take priority over clear_flags in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            dec_cnt   <= '0;
            sat_flag  <= 1'b0;
            drop_flag <= 1'b0;
        end else begin
            if (s2_valid)
                dec_cnt <= (dec_cnt == DCW'(DECIM - 1)) ? '0 : dec_cnt + DCW'(1);
            if (sat_ev)           sat_flag <= 1'b1;
            else if (clear_flags) sat_flag <= 1'b0;
            if (drop_ev)          drop_flag <= 1'b1;
            else if (clear_flags) drop_flag <= 1'b0;
        end
    end

`ifdef FIR_OUT_QUANTIZER_SATCNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            sat_count <= '0;
        end else if (clear_flags) begin
            sat_count <= sat_ev ? 16'd1 : 16'd0;
        end else if (sat_ev && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end
`endif

    fir_out_fifo #(
        .WIDTH (OUTPUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (s2_data),
        .pop       (pop),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (unused_fifo_count)
    );

    assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_fir_out_quantizer.sv
// Directed bench for fir_out_quantizer: one DECIM=1 and one DECIM=4 instance share stimulus.
module tb_fir_out_quantizer;

    logic        clk = 1'b0;
    logic        reset;
    logic [32:0] in_data;
    logic        in_valid;
    logic        out_ready;
    logic        clear_flags;
    logic [15:0] out_data1, out_data4;
    logic        out_valid1, out_valid4;
    logic        sat1, sat4, drop1, drop4;
`ifdef FIR_OUT_QUANTIZER_SATCNT_EN
    logic [15:0] satcnt1, satcnt4;
`endif

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    fir_out_quantizer #(.DECIM(1)) dut1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
        .clear_flags(clear_flags), .sat_flag(sat1), .drop_flag(drop1)
`ifdef FIR_OUT_QUANTIZER_SATCNT_EN
        , .sat_count(satcnt1)
`endif
    );

    fir_out_quantizer #(.DECIM(4)) dut4 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready),
        .clear_flags(clear_flags), .sat_flag(sat4), .drop_flag(drop4)
`ifdef FIR_OUT_QUANTIZER_SATCNT_EN
        , .sat_count(satcnt4)
`endif
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input longint v);
        in_data  = 33'(v);
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
    endtask

    // One sample through an idle DECIM=1 path: absent after 2 edges, present after 3.
    task automatic send_check(input string tag, input longint v, input logic [15:0] exp);
        drive(v);
        tick(1);
        chk({tag, "_lat"}, 32'(out_valid1), 32'd0);
        tick(1);
        chk({tag, "_valid"}, 32'(out_valid1), 32'd1);
        chk({tag, "_data"}, 32'(out_data1), 32'(exp));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        logic [15:0] q1[$];
        logic [15:0] q4[$];

        reset = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b1; clear_flags = 1'b0;
        tick(2);
        reset = 1'b0;
        chk("rst_valid", 32'(out_valid1), 32'd0);
        chk("rst_data", 32'(out_data1), 32'd0);
        chk("rst_sat", 32'(sat1), 32'd0);
        chk("rst_drop", 32'(drop1), 32'd0);
        chk("rst_valid4", 32'(out_valid4), 32'd0);

        // Rounding: half-up at the shift boundary.
        send_check("rnd_p", 64'sd32768, 16'd1);
        send_check("rnd_n", -64'sd32768, 16'd0);
        send_check("rnd_x", 64'sd98303, 16'd1);
        chk("nosat", 32'(sat1), 32'd0);

        // Saturation at both rails, then clear.
        send_check("sat_pos", 64'sd2147483648, 16'h7FFF);
        chk("sat_flag", 32'(sat1), 32'd1);
        send_check("sat_neg", -64'sd4294967296, 16'h8000);
        clear_flags = 1'b1;
        tick(1);
        clear_flags = 1'b0;
        chk("sat_clr", 32'(sat1), 32'd0);
        chk("sat_clr4", 32'(sat4), 32'd0);

        // Decimation by 4 on k*65536, k=0..7.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            if (i < 8) begin
                in_data  = 33'(longint'(i) <<< 16);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick(1);
            if (out_valid1) q1.push_back(out_data1);
            if (out_valid4) q4.push_back(out_data4);
        end
        in_valid = 1'b0;
        chk("dec4_cnt", 32'(q4.size()), 32'd2);
        if (q4.size() == 2) begin
            chk("dec4_first", 32'(q4[0]), 32'd0);
            chk("dec4_second", 32'(q4[1]), 32'd4);
        end
        chk("dec1_cnt", 32'(q1.size()), 32'd8);
        if (q1.size() == 8) begin
            chk("dec1_s3", 32'(q1[3]), 32'd3);
            chk("dec1_s7", 32'(q1[7]), 32'd7);
        end

        // Overflow: 5 samples into a 4-deep FIFO with no consumer.
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) drive(longint'(k) <<< 16);
        tick(3);
        chk("ovf_valid", 32'(out_valid1), 32'd1);
        chk("ovf_head", 32'(out_data1), 32'd1);
        chk("ovf_drop", 32'(drop1), 32'd1);
        tick(1);
        chk("ovf_hold", 32'(out_data1), 32'd1);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("ovf_drain", 32'(out_data1), 32'(k));
            tick(1);
        end
        chk("ovf_empty", 32'(out_valid1), 32'd0);
        clear_flags = 1'b1;
        tick(1);
        clear_flags = 1'b0;
        chk("drop_clr", 32'(drop1), 32'd0);

        // Full FIFO with a push and pop on the same edge.
        out_ready = 1'b0;
        for (int k = 10; k <= 13; k++) drive(longint'(k) <<< 16);
        tick(3);
        chk("pp_head", 32'(out_data1), 32'd10);
        drive(longint'(14) <<< 16);
        tick(1);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        chk("pp_drop", 32'(drop1), 32'd0);
        chk("pp_head2", 32'(out_data1), 32'd11);
        out_ready = 1'b1;
        for (int k = 11; k <= 14; k++) begin
            chk("pp_drain", 32'(out_data1), 32'(k));
            tick(1);
        end
        chk("pp_empty", 32'(out_valid1), 32'd0);
        chk("pp_drop2", 32'(drop1), 32'd0);

        // Reset with buffered and in-flight samples (DECIM=4 keeps 1, 5, 9).
        do_reset();
        out_ready = 1'b0;
        for (int k = 1; k <= 14; k++) drive(longint'(k) <<< 16);
        chk("mid_valid4", 32'(out_valid4), 32'd1);
        chk("mid_head4", 32'(out_data4), 32'd1);
        reset    = 1'b1;
        in_data  = 33'(longint'(99) <<< 16);
        in_valid = 1'b1;
        tick(1);
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("mr_valid4", 32'(out_valid4), 32'd0);
        chk("mr_data4", 32'(out_data4), 32'd0);
        chk("mr_drop1", 32'(drop1), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("mr_stale4", 32'(out_valid4), 32'd0);
            chk("mr_stale1", 32'(out_valid1), 32'd0);
        end
        out_ready = 1'b1;
        drive(longint'(20) <<< 16);
        tick(1);
        chk("mr_lat4", 32'(out_valid4), 32'd0);
        tick(1);
        chk("mr_first4", 32'(out_valid4), 32'd1);
        chk("mr_first4_data", 32'(out_data4), 32'd20);
        drive(longint'(21) <<< 16);
        tick(4);
        chk("mr_skip4", 32'(out_valid4), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
